// File: rtl/ct_ebiu_cawt_pkg.sv
// CAWT shared types: entry layout, index slice bounds and the
// mid-to-PIU select decode.
package ct_ebiu_cawt_pkg;

    localparam int CAWT_ENTRY_NUM = 8;
    localparam int CAWT_IDX_LSB   = 6;
    localparam int CAWT_IDX_MSB   = 13;
    localparam int CAWT_IDX_W     = CAWT_IDX_MSB - CAWT_IDX_LSB + 1;
    localparam int CAWT_ID_W      = 8;

    typedef struct packed {
        logic                  vld;
        logic [CAWT_IDX_W-1:0] idx;
        logic [CAWT_ID_W-1:0]  id;
        logic [2:0]            mid;
    } cawt_entry_t;

    // mid[2] broadcasts to every PIU
    function automatic logic [3:0] cawt_mid_sel(input logic [2:0] mid);
        return (4'b0001 << mid[1:0]) | {4{mid[2]}};
    endfunction

endpackage

// File: rtl/ct_ebiu_cawt_age_mtx.sv
// CAWT age matrix: row i holds the entries older than entry i;
// picks the oldest entry among a match vector.
module ct_ebiu_cawt_age_mtx
    import ct_ebiu_cawt_pkg::*;
#(
    parameter int N = CAWT_ENTRY_NUM
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [N-1:0] vld,
    input  logic [N-1:0] alloc,
    input  logic [N-1:0] pop,
    input  logic [N-1:0] match,
    output logic [N-1:0] oldest
);

    logic [N-1:0] age [N];

    // a fresh row is older-than everything still valid after this edge
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < N; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (alloc[i]) begin
                    age[i] <= vld & ~pop;
                end else begin
                    age[i] <= age[i] & ~pop;
                end
            end
        end
    end

    always_comb begin
        oldest = '0;
        for (int i = 0; i < N; i++) begin
            oldest[i] = match[i] & ~|(age[i] & match);
        end
    end

endmodule

// File: rtl/ct_ebiu_cawt_ctrl.sv
// EBIU non-cacheable write table: allocate on AW, retire oldest
// same-ID entry on B, report line-index hits for reads and snoops.
module ct_ebiu_cawt_ctrl
    import ct_ebiu_cawt_pkg::*;
#(
    parameter int ENTRY_NUM = CAWT_ENTRY_NUM,
    parameter int ID_W      = CAWT_ID_W,
    parameter int IDX_W     = CAWT_IDX_W
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             vb_cawt_create_req,
    input  logic [39:0]      vb_ebiu_awaddr,
    input  logic [ID_W-1:0]  vb_ebiu_awid,
    input  logic [2:0]       vb_ebiu_mid,
    output logic             cawt_create_ack,
    input  logic             pad_ebiu_bvalid,
    input  logic [ID_W-1:0]  pad_ebiu_bid,
    input  logic [39:0]      ebiuif_ebiu_araddr,
    input  logic [IDX_W-1:0] snb0_yy_snpext_index,
    input  logic [IDX_W-1:0] snb1_yy_snpext_index,
    output logic             ca_rd_addr_hit_cawt,
    output logic             ca_wr_addr_hit_cawt,
    output logic             snb0_snpext_addr_hit_cawt,
    output logic             snb1_snpext_addr_hit_cawt,
    output logic [3:0]       cawt_piu_sel,
    output logic             cawt_full,
    output logic             cawt_empty,
    output logic             cawt_bresp_err
);

    logic [ENTRY_NUM-1:0] vld;
    logic [ENTRY_NUM-1:0] free;
    logic [ENTRY_NUM-1:0] alloc_oh;
    logic [ENTRY_NUM-1:0] match;
    logic [ENTRY_NUM-1:0] pop_oh;
    logic [ENTRY_NUM-1:0] rd_hit;
    logic [ENTRY_NUM-1:0] wr_hit;
    logic [ENTRY_NUM-1:0] s0_hit;
    logic [ENTRY_NUM-1:0] s1_hit;
    logic [ENTRY_NUM-1:0] id_eq;
    logic [3:0]           sel [ENTRY_NUM];
    logic [IDX_W-1:0]     aw_idx;
    logic [IDX_W-1:0]     ar_idx;

    assign aw_idx = vb_ebiu_awaddr[CAWT_IDX_MSB:CAWT_IDX_LSB];
    assign ar_idx = ebiuif_ebiu_araddr[CAWT_IDX_MSB:CAWT_IDX_LSB];

    assign cawt_full       = &vld;
    assign cawt_empty      = ~|vld;
    assign cawt_create_ack = vb_cawt_create_req & ~cawt_full;

    // lowest-index free slot
    assign free     = ~vld;
    assign alloc_oh = cawt_create_ack
                    ? (free & (~free + ENTRY_NUM'(1)))
                    : '0;

    assign match = {ENTRY_NUM{pad_ebiu_bvalid}} & vld & id_eq;

    ct_ebiu_cawt_age_mtx #(
        .N (ENTRY_NUM)
    ) u_age_mtx (
        .clk    (forever_cpuclk),
        .rst_b  (cpurst_b),
        .vld    (vld),
        .alloc  (alloc_oh),
        .pop    (pop_oh),
        .match  (match),
        .oldest (pop_oh)
    );

    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_ent
        cawt_entry_t ent;

        always_ff @(posedge forever_cpuclk) begin
            if (!cpurst_b) begin
                ent <= '0;
            end else if (alloc_oh[i]) begin
                ent.vld <= 1'b1;
                ent.idx <= aw_idx;
                ent.id  <= vb_ebiu_awid;
                ent.mid <= vb_ebiu_mid;
            end else if (pop_oh[i]) begin
                ent.vld <= 1'b0;
            end
        end

        assign vld[i]    = ent.vld;
        assign id_eq[i]  = ent.id == pad_ebiu_bid;
        assign rd_hit[i] = ent.vld & (ent.idx == ar_idx);
        assign wr_hit[i] = ent.vld & (ent.idx == aw_idx);
        assign s0_hit[i] = ent.vld & (ent.idx == snb0_yy_snpext_index);
        assign s1_hit[i] = ent.vld & (ent.idx == snb1_yy_snpext_index);
        assign sel[i]    = ent.vld ? cawt_mid_sel(ent.mid) : 4'b0000;
    end

    assign ca_rd_addr_hit_cawt       = |rd_hit;
    assign ca_wr_addr_hit_cawt       = |wr_hit;
    assign snb0_snpext_addr_hit_cawt = |s0_hit;
    assign snb1_snpext_addr_hit_cawt = |s1_hit;

    always_comb begin
        cawt_piu_sel = 4'b0000;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            cawt_piu_sel = cawt_piu_sel | sel[i];
        end
    end

    // sticky until reset: a B with no owner
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            cawt_bresp_err <= 1'b0;
        end else if (pad_ebiu_bvalid && ~|match) begin
            cawt_bresp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ct_ebiu_cawt_ctrl.sv
// Bench for ct_ebiu_cawt_ctrl: directed steps then random traffic
// against a timestamp-based table model.
module tb_ct_ebiu_cawt_ctrl;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        create_req = 1'b0;
    logic [39:0] awaddr = '0;
    logic [7:0]  awid = '0;
    logic [2:0]  mid = '0;
    logic        ack;
    logic        bvalid = 1'b0;
    logic [7:0]  bid = '0;
    logic [39:0] araddr = '0;
    logic [7:0]  snb0 = '0;
    logic [7:0]  snb1 = '0;
    logic        rd_hit, wr_hit, s0_hit, s1_hit;
    logic [3:0]  piu_sel;
    logic        full, empty, berr;

    int tests = 0;
    int fails = 0;

    bit         m_vld [N];
    logic [7:0] m_idx [N];
    logic [7:0] m_id  [N];
    logic [2:0] m_mid [N];
    int         m_stamp [N];
    int         stamp_ctr = 0;
    bit         m_err = 0;

    always #5 clk = ~clk;

    ct_ebiu_cawt_ctrl dut (
        .forever_cpuclk            (clk),
        .cpurst_b                  (rst_b),
        .vb_cawt_create_req        (create_req),
        .vb_ebiu_awaddr            (awaddr),
        .vb_ebiu_awid              (awid),
        .vb_ebiu_mid               (mid),
        .cawt_create_ack           (ack),
        .pad_ebiu_bvalid           (bvalid),
        .pad_ebiu_bid              (bid),
        .ebiuif_ebiu_araddr        (araddr),
        .snb0_yy_snpext_index      (snb0),
        .snb1_yy_snpext_index      (snb1),
        .ca_rd_addr_hit_cawt       (rd_hit),
        .ca_wr_addr_hit_cawt       (wr_hit),
        .snb0_snpext_addr_hit_cawt (s0_hit),
        .snb1_snpext_addr_hit_cawt (s1_hit),
        .cawt_piu_sel              (piu_sel),
        .cawt_full                 (full),
        .cawt_empty                (empty),
        .cawt_bresp_err            (berr)
    );

    function automatic logic [39:0] mk_addr(input logic [7:0] idx);
        logic [17:0] hi;
        logic [5:0]  lo;
        hi = 18'($urandom);
        lo = 6'($urandom);
        return {8'h00, hi, idx, lo};
    endfunction

    function automatic logic [3:0] piu_of(input logic [2:0] m);
        logic [3:0] r;
        if (m[2]) r = 4'hF;
        else begin
            case (m[1:0])
                2'd0: r = 4'h1;
                2'd1: r = 4'h2;
                2'd2: r = 4'h4;
                default: r = 4'h8;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_vld[i] = 0;
        m_err = 0;
    endtask

    task automatic cyc(input bit req, input logic [7:0] aidx,
                       input logic [7:0] aid, input logic [2:0] amid,
                       input bit bv, input logic [7:0] b,
                       input logic [7:0] ridx, input logic [7:0] s0,
                       input logic [7:0] s1);
        int cnt, pick, free_slot;
        bit e_full, e_ack, e_rd, e_wr, e_s0, e_s1;
        logic [3:0] e_sel;
        create_req = req;
        awaddr     = mk_addr(aidx);
        awid       = aid;
        mid        = amid;
        bvalid     = bv;
        bid        = b;
        araddr     = mk_addr(ridx);
        snb0       = s0;
        snb1       = s1;
        #1;
        cnt = 0; e_rd = 0; e_wr = 0; e_s0 = 0; e_s1 = 0; e_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (m_vld[i]) begin
                cnt++;
                e_rd  |= (m_idx[i] == ridx);
                e_wr  |= (m_idx[i] == aidx);
                e_s0  |= (m_idx[i] == s0);
                e_s1  |= (m_idx[i] == s1);
                e_sel |= piu_of(m_mid[i]);
            end
        end
        e_full = (cnt == N);
        e_ack  = req && !e_full;
        chk("ack",     32'(ack),     32'(e_ack));
        chk("full",    32'(full),    32'(e_full));
        chk("empty",   32'(empty),   32'(cnt == 0));
        chk("piu_sel", 32'(piu_sel), 32'(e_sel));
        chk("rd_hit",  32'(rd_hit),  32'(e_rd));
        chk("wr_hit",  32'(wr_hit),  32'(e_wr));
        chk("snb0",    32'(s0_hit),  32'(e_s0));
        chk("snb1",    32'(s1_hit),  32'(e_s1));
        chk("berr",    32'(berr),    32'(m_err));
        @(posedge clk);
        if (!rst_b) begin
            model_clear();
        end else begin
            free_slot = -1;
            for (int i = N - 1; i >= 0; i--) if (!m_vld[i]) free_slot = i;
            if (bv) begin
                pick = -1;
                for (int i = 0; i < N; i++)
                    if (m_vld[i] && m_id[i] == b &&
                        (pick < 0 || m_stamp[i] < m_stamp[pick]))
                        pick = i;
                if (pick < 0) m_err = 1;
                else m_vld[pick] = 0;
            end
            if (e_ack) begin
                m_vld[free_slot]   = 1;
                m_idx[free_slot]   = aidx;
                m_id[free_slot]    = aid;
                m_mid[free_slot]   = amid;
                m_stamp[free_slot] = stamp_ctr++;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [7:0] ridx);
        cyc(0, 8'hEE, 0, 0, 0, 0, ridx, 8'hED, 8'hEC);
    endtask

    initial begin
        logic [7:0] ids [N];
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst_b = 1'b1;

        // 1: reset state
        idle(8'h00);

        // 2: single create / retire
        cyc(1, 8'h7F, 8'h05, 3'b001, 0, 0, 8'h7F, 8'h7F, 8'h00);
        idle(8'h7F);
        cyc(0, 8'h00, 0, 0, 1, 8'h05, 8'h7F, 8'h7F, 8'h7F);
        idle(8'h7F);

        // 3: same ID pops in allocation order
        cyc(1, 8'h10, 8'h0A, 3'b000, 0, 0, 8'h10, 8'h11, 8'h12);
        cyc(1, 8'h11, 8'h0A, 3'b001, 0, 0, 8'h10, 8'h11, 8'h12);
        cyc(1, 8'h12, 8'h0A, 3'b010, 0, 0, 8'h10, 8'h11, 8'h12);
        for (int k = 0; k < 4; k++)
            cyc(0, 8'h12, 0, 0, k < 3, 8'h0A, 8'h10, 8'h11, 8'h12);

        // 4: fill, full blocks create, freed slot reused next cycle
        for (int i = 0; i < N; i++) begin
            ids[i] = 8'(8'h40 + i);
            cyc(1, 8'(8'h20 + i), ids[i], 3'(i), 0, 0, 8'h23, 8'h20, 8'h27);
        end
        cyc(1, 8'h55, 8'hAA, 3'b011, 1, ids[3], 8'h23, 8'h55, 8'h27);
        cyc(1, 8'h55, 8'hAA, 3'b011, 0, 0, 8'h55, 8'h23, 8'h27);
        idle(8'h55);

        // 5: unmatched B is sticky, reset clears it
        cyc(0, 8'h00, 0, 0, 1, 8'h33, 8'h21, 8'h22, 8'h24);
        idle(8'h21);
        idle(8'h22);
        rst_b = 1'b0;
        idle(8'h21);
        rst_b = 1'b1;
        idle(8'h21);

        // 6: broadcast mid, snoop hits, mid-operation reset
        cyc(1, 8'h66, 8'h01, 3'b100, 0, 0, 8'h66, 8'h66, 8'h67);
        cyc(0, 8'h66, 0, 0, 0, 0, 8'h66, 8'h66, 8'h67);
        for (int i = 0; i < 4; i++)
            cyc(1, 8'(8'h70 + i), 8'(i + 2), 3'(i), 0, 0, 8'h70, 8'h66, 8'h71);
        rst_b = 1'b0;
        cyc(1, 8'h70, 8'h09, 3'b000, 0, 0, 8'h70, 8'h66, 8'h71);
        rst_b = 1'b1;
        cyc(0, 8'h70, 0, 0, 0, 0, 8'h70, 8'h66, 8'h71);

        // random traffic with colliding IDs and indices
        for (int c = 0; c < 600; c++) begin
            logic [7:0] b;
            int j;
            bit bv;
            bv = ($urandom_range(0, 2) == 0);
            j  = $urandom_range(0, N - 1);
            b  = m_vld[j] ? m_id[j] : 8'($urandom_range(0, 3));
            if ($urandom_range(0, 40) == 0) b = 8'h99;
            cyc($urandom_range(0, 1), 8'($urandom_range(0, 7)),
                8'($urandom_range(0, 3)), 3'($urandom),
                bv, b, 8'($urandom_range(0, 7)),
                8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
            if (c == 300) begin
                rst_b = 1'b0;
                idle(8'h00);
                rst_b = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
